// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and flag controller for a dual-clock FIFO (write clock domain only).
// Optional sticky overflow flag with synchronous clear is enabled by WR_OVERFLOW_FLAG_EN.
module async_fifo_wr_ctrl #(
    parameter int unsigned PTR_WIDTH = 5,
    parameter int unsigned AF_THRESH = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH:0]   rq2_wgray_rptr,
`ifdef WR_OVERFLOW_FLAG_EN
    input  logic                 ovf_clr,
    output logic                 wr_overflow,
`endif
    output logic                 wr_accept,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level
);

    localparam logic [PTR_WIDTH:0] AfThresh = AF_THRESH[PTR_WIDTH:0];
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    localparam logic [PTR_WIDTH:0] FullMask = {2'b11, {(PTR_WIDTH - 1){1'b0}}};

    logic [PTR_WIDTH:0] wbin_q, wbin_d;
    logic [PTR_WIDTH:0] wgray_q, wgray_d;
    logic [PTR_WIDTH:0] level_q, level_d;
    logic               full_q, full_d;
    logic               almost_full_q, almost_full_d;
    logic [PTR_WIDTH:0] rbin_sync;

    assign wr_accept = wr_en & ~full_q;

    always_comb begin
        rbin_sync = '0;
        rbin_sync[PTR_WIDTH] = rq2_wgray_rptr[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            rbin_sync[i] = rbin_sync[i+1] ^ rq2_wgray_rptr[i];
        end
    end

    always_comb begin
        wbin_d        = wbin_q + {{PTR_WIDTH{1'b0}}, wr_accept};
        wgray_d       = wbin_d ^ (wbin_d >> 1);
        level_d       = wbin_d - rbin_sync;
        full_d        = (wgray_d == (rq2_wgray_rptr ^ FullMask));
        almost_full_d = (level_d >= AfThresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q        <= '0;
            wgray_q       <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wgray_q       <= wgray_d;
            level_q       <= level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign waddr       = wbin_q[PTR_WIDTH-1:0];
    assign wptr_gray   = wgray_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wr_level    = level_q;

`ifdef WR_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    // Set has priority over clear so a dropped write is never lost to a coincident clear.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign wr_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl: directed scenarios plus randomized traffic
// against a count-based model of the FIFO (write count, read count, occupancy).
module tb_async_fifo_wr_ctrl;

    localparam int PW    = 5;
    localparam int DEPTH = 1 << PW;
    localparam int AF    = 28;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [PW:0]   rq2 = '0;
    logic          wr_accept;
    logic [PW-1:0] waddr;
    logic [PW:0]   wptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW:0]   wr_level;
`ifdef WR_OVERFLOW_FLAG_EN
    logic          ovf_clr = 1'b0;
    logic          wr_overflow;
`endif

    async_fifo_wr_ctrl #(
        .PTR_WIDTH (PW),
        .AF_THRESH (AF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .rq2_wgray_rptr (rq2),
`ifdef WR_OVERFLOW_FLAG_EN
        .ovf_clr        (ovf_clr),
        .wr_overflow    (wr_overflow),
`endif
        .wr_accept      (wr_accept),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .wr_level       (wr_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: total writes accepted, total reads seen by the write side, occupancy.
    int w     = 0;
    int r     = 0;
    bit mfull = 1'b0;
    bit movf  = 1'b0;
    logic [PW:0] prev_gray;

    function automatic logic [PW:0] gray(input int v);
        logic [PW:0] b;
        b = (PW + 1)'(v % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_gray", 32'(wptr_gray), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_level", 32'(wr_level), 32'd0);
`ifdef WR_OVERFLOW_FLAG_EN
        chk("rst_ovf", 32'(wr_overflow), 32'd0);
`endif
    endtask

    // One clock of stimulus; inputs change 1 time unit after a rising edge.
    task automatic step(input bit en, input int radv, input bit clr);
        bit acc;
        int lvl;
        wr_en = en;
        r += radv;
        rq2 = gray(r);
`ifdef WR_OVERFLOW_FLAG_EN
        ovf_clr = clr;
`endif
        #1;
        acc = en && !mfull;
        chk("wr_accept", 32'(wr_accept), 32'(acc));
        prev_gray = wptr_gray;
        @(posedge clk);
        if (en && mfull) movf = 1'b1;
        else if (clr) movf = 1'b0;
        w += int'(acc);
        lvl = w - r;
        mfull = (lvl == DEPTH);
        #1;
        chk("wptr_gray", 32'(wptr_gray), 32'(gray(w)));
        chk("gray_1bit", 32'($countones(prev_gray ^ wptr_gray)), 32'(acc));
        chk("waddr", 32'(waddr), 32'(w % DEPTH));
        chk("wr_level", 32'(wr_level), 32'(lvl));
        chk("full", 32'(full), 32'(mfull));
        chk("almost_full", 32'(almost_full), 32'(lvl >= AF));
`ifdef WR_OVERFLOW_FLAG_EN
        chk("wr_overflow", 32'(wr_overflow), 32'(movf));
`endif
    endtask

    initial begin
        int radv;
        int mode;
        #2;
        chk_zero();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reach wbin=13, then reset asynchronously between edges.
        for (int i = 0; i < 13; i++) step(1'b1, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_zero();
        w = 0; r = 0; mfull = 1'b0; movf = 1'b0;
        wr_en = 1'b0; rq2 = '0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("waddr_first", 32'(waddr), 32'd0);

        // Fill to full with the read pointer parked at 0.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 0, 1'b0);
        chk("fill_level", 32'(wr_level), 32'(DEPTH));
        chk("fill_full", 32'(full), 32'd1);

        // Writes while full are dropped.
        for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0);
        chk("full_level_hold", 32'(wr_level), 32'(DEPTH));
`ifdef WR_OVERFLOW_FLAG_EN
        chk("ovf_set", 32'(wr_overflow), 32'd1);
        step(1'b0, 0, 1'b1);
        chk("ovf_clr", 32'(wr_overflow), 32'd0);
`endif

        // Drain one entry.
        step(1'b0, 1, 1'b0);
        chk("drain_level", 32'(wr_level), 32'(DEPTH - 1));
        chk("drain_full", 32'(full), 32'd0);

        // Wrap: keep writing while the reader closes to 8 behind, crossing 63->0.
        for (int i = 0; i < 40; i++) begin
            radv = (w - r > 8) ? 2 : 1;
            step(1'b1, radv, 1'b0);
        end

        // Simultaneous write and read at level 20.
        while (w - r < 20) step(1'b1, 0, 1'b0);
        chk("sim_pre", 32'(wr_level), 32'd20);
        step(1'b1, 1, 1'b0);
        chk("sim_level", 32'(wr_level), 32'd20);

        // Randomized traffic with phases biased toward fill, drain and balance.
        for (int i = 0; i < 600; i++) begin
            bit en;
            bit clr;
            int maxr;
            mode = (i / 50) % 3;
            unique case (mode)
                0: en = ($urandom_range(0, 9) < 9);
                1: en = ($urandom_range(0, 9) < 2);
                default: en = ($urandom_range(0, 1) == 1);
            endcase
            maxr = (w - r < 2) ? (w - r) : 2;
            radv = (mode == 0 && $urandom_range(0, 3) != 0) ? 0 : $urandom_range(0, maxr);
            clr = ($urandom_range(0, 15) == 0);
            step(en, radv, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
